serial_comp_sched: RTL

Round-robin scheduler that time-shares one serial 2's-complement engine among NREQ requesters. It grants one requester, loads that requester's operand into the engine, and shifts it LSB-first for WIDTH cycles. It then returns the complemented word with a one-cycle acknowledge. It sits between the parallel-word requesters and a single `serial_comp_core` instance, replacing one complementer per requester.

---
 rtl/serial_comp_pkg.sv | 21 ++
 rtl/serial_comp_core.sv | 32 +++
 rtl/serial_comp_sched.sv | 78 +++++++
 3 files changed

// File: rtl/serial_comp_pkg.sv
// Shared types and helpers for the time-shared serial 2's-complement scheduler.
package serial_comp_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ  = 4;
  localparam int MAX_NREQ  = 32;

  // First set request at or after ptr, wrapping at nreq-1 -> 0; returns ptr if none set.
  function automatic int rr_pick(input logic [MAX_NREQ-1:0] req, input int ptr, input int nreq);
    int idx;
    rr_pick = ptr;
    for (int k = MAX_NREQ - 1; k >= 0; k--) begin
      if (k < nreq) begin
        idx = ptr + k;
        if (idx >= nreq) idx = idx - nreq;
        if (req[idx]) rr_pick = idx;
      end
    end
  endfunction
endpackage

// File: rtl/serial_comp_core.sv
// LSB-first serial 2's-complement engine: shift register plus seen-one flag.
module serial_comp_core
  import serial_comp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_sr;
  logic             r_flag;

  // Result bits re-enter at the MSB, so after WIDTH shifts r_sr holds the full result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr   <= '0;
      r_flag <= 1'b0;
    end else if (load) begin
      r_sr   <= d;
      r_flag <= 1'b0;
    end else if (shift_en) begin
      r_sr   <= {r_sr[0] ^ r_flag, r_sr[WIDTH-1:1]};
      r_flag <= r_flag | r_sr[0];
    end
  end

  assign q = r_sr;
endmodule

// File: rtl/serial_comp_sched.sv
// Round-robin scheduler sharing one serial complementer among NREQ requesters.
module serial_comp_sched
  import serial_comp_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data_in,
  output logic [NREQ-1:0]         ack,
  output logic [WIDTH-1:0]        data_out,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [GW-1:0]    r_gid;
  logic [GW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_opnd;
  logic [WIDTH-1:0] w_q;

  assign w_opnd = data_in[r_gid*WIDTH +: WIDTH];

  serial_comp_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (r_state == ST_LOAD),
    .shift_en (r_state == ST_SHIFT),
    .d        (w_opnd),
    .q        (w_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gid   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_dout  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (|req) begin
          r_gid   <= GW'(rr_pick(MAX_NREQ'(req), int'(r_ptr), NREQ));
          r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_cnt   <= '0;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_dout  <= w_q;
          r_ptr   <= (r_gid == GW'(NREQ - 1)) ? '0 : r_gid + 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The engine already holds the finished word during DONE; show it then, hold the copy after.
  assign data_out = (r_state == ST_DONE) ? w_q : r_dout;
  assign busy     = (r_state != ST_IDLE);
  assign grant_id = r_gid;

  for (genvar i = 0; i < NREQ; i++) begin : g_ack
    assign ack[i] = (r_state == ST_DONE) && (r_gid == GW'(i));
  end
endmodule
